// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller_pkg
// Brief   : Shared pipeline types and widths used by the hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

  // Register-file address width and datapath word width of the core
  localparam int ADDR_WIDTH = 4;
  localparam int WORD       = 32;

  // Hazard sequencer states; encoding is visible on the debug state port
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } hazard_state_t;

  // Writeback source selector of the register file
  typedef enum logic {
    RF_SRC_ALU = 1'b0,
    RF_SRC_MEM = 1'b1
  } reg_file_data_source_t;

endpackage : pipeline_hazard_controller_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Brief   : Load-use hazard compare between ID source operands and EX load dest.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int ADDR_WIDTH = pipeline_hazard_controller_pkg::ADDR_WIDTH
) (
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_src1_addr_i,
  input  logic [ADDR_WIDTH-1:0] id_src2_addr_i,
  input  logic [1:0]            id_src_used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_load_i,
  input  logic [ADDR_WIDTH-1:0] ex_dest_addr_i,
  output logic                  hazard_o
);

  import pipeline_hazard_controller_pkg::*;

  logic src1_match;
  logic src2_match;

  // Register 0 is an ordinary register here, so no zero-register exclusion
  always_comb begin
    src1_match = id_src_used_i[0] & (id_src1_addr_i == ex_dest_addr_i);
    src2_match = id_src_used_i[1] & (id_src2_addr_i == ex_dest_addr_i);
    hazard_o   = id_valid_i & ex_valid_i & ex_is_load_i & (src1_match | src2_match);
  end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller
// Brief   : Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
//           wrong-path squash after taken branches, freeze on memory waits.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int ADDR_WIDTH   = pipeline_hazard_controller_pkg::ADDR_WIDTH,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOADUSE_GAP  = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_src1_addr_i,
  input  logic [ADDR_WIDTH-1:0] id_src2_addr_i,
  input  logic [1:0]            id_src_used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_load_i,
  input  logic [ADDR_WIDTH-1:0] ex_dest_addr_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  id_ex_stall_o,
  output logic                  ex_mem_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_valid_o,
  output logic [1:0]            state_o
);

  import pipeline_hazard_controller_pkg::*;

  localparam int MAX_CNT = (FLUSH_CYCLES > LOADUSE_GAP) ? FLUSH_CYCLES : LOADUSE_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(LOADUSE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  hazard_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_branch, pend_nxt;
  logic             hazard;
  logic             mem_wait;
  logic             branch_eff;
  logic             run_eval;

  hazard_detect #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hazard_detect (
    .id_valid_i     (id_valid_i),
    .id_src1_addr_i (id_src1_addr_i),
    .id_src2_addr_i (id_src2_addr_i),
    .id_src_used_i  (id_src_used_i),
    .ex_valid_i     (ex_valid_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_dest_addr_i (ex_dest_addr_i),
    .hazard_o       (hazard)
  );

  // State, countdown and deferred-branch registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ST_RUN;
      cnt         <= '0;
      pend_branch <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend_branch <= pend_nxt;
    end
  end

  // Next state and 0-latency controls; priority mem wait > branch > load-use
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pend_nxt       = pend_branch;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    run_eval       = 1'b0;
    mem_wait       = mem_req_i & ~mem_ready_i;
    // A branch resolved while frozen is remembered and acted on once memory frees up
    branch_eff     = ex_branch_taken_i | pend_branch;

    if (mem_wait) begin
      // Freeze everything; FLUSH/LOAD_USE keep their remaining count for later
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      pend_nxt       = pend_branch | ex_branch_taken_i;
      if (state == ST_RUN) state_nxt = ST_MEM_WAIT;
    end else begin
      unique case (state)
        ST_FLUSH: begin
          // Wrong-path instructions may look like hazards; only a new branch matters
          if (branch_eff) begin
            run_eval = 1'b1;
          end else if (cnt != '0) begin
            if_id_flush_o = 1'b1;
            cnt_nxt       = cnt - CNT_ONE;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_LOAD_USE: begin
          if (cnt != '0 && !branch_eff) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
            cnt_nxt       = cnt - CNT_ONE;
          end else begin
            run_eval = 1'b1;
          end
        end
        default: run_eval = 1'b1;
      endcase

      // Normal-flow decision shared by RUN, wait exit and the end of a bubble run
      if (run_eval) begin
        state_nxt = ST_RUN;
        if (branch_eff) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          pend_nxt      = 1'b0;
          cnt_nxt       = FLUSH_LOAD;
          state_nxt     = ST_FLUSH;
        end else if (hazard) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
          cnt_nxt       = GAP_LOAD;
          state_nxt     = ST_LOAD_USE;
        end
      end
    end

    // Reset forces a clean pipeline regardless of the clock
    if (!reset_n_i) begin
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      id_ex_stall_o  = 1'b0;
      ex_mem_stall_o = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end
  end

  // A held EX/MEM register keeps its content, so its load must not be marked valid
  assign ex_mem_valid_o = reset_n_i & ex_valid_i & ~ex_mem_stall_o;
  assign state_o        = state;

endmodule : pipeline_hazard_controller
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_controller
// Brief   : Directed vector bench for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  typedef struct {
    logic       idv;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] used;
    logic       exv;
    logic       ld;
    logic [3:0] d;
    logic       br;
    logic       mrq;
    logic       mrd;
    logic [6:0] ctl;   // {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, exmem_v}
    logic [1:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid;
  logic [3:0] src1, src2, dest;
  logic [1:0] used;
  logic       ex_valid, ex_load, br_taken, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_valid;
  logic [1:0] state;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  pipeline_hazard_controller #(
    .ADDR_WIDTH   (4),
    .FLUSH_CYCLES (2),
    .LOADUSE_GAP  (1)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .id_valid_i        (id_valid),
    .id_src1_addr_i    (src1),
    .id_src2_addr_i    (src2),
    .id_src_used_i     (used),
    .ex_valid_i        (ex_valid),
    .ex_is_load_i      (ex_load),
    .ex_dest_addr_i    (dest),
    .ex_branch_taken_i (br_taken),
    .mem_req_i         (mem_req),
    .mem_ready_i       (mem_ready),
    .pc_stall_o        (pc_stall),
    .if_id_stall_o     (if_id_stall),
    .id_ex_stall_o     (id_ex_stall),
    .ex_mem_stall_o    (ex_mem_stall),
    .if_id_flush_o     (if_id_flush),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_valid_o    (ex_mem_valid),
    .state_o           (state)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic vec_t mk(logic idv, logic [3:0] s1, logic [3:0] s2, logic [1:0] u,
                              logic exv, logic ld, logic [3:0] d, logic br,
                              logic mrq, logic mrd, logic [6:0] ctl, logic [1:0] st);
    vec_t v;
    v.idv = idv; v.s1 = s1; v.s2 = s2; v.used = u; v.exv = exv; v.ld = ld;
    v.d = d; v.br = br; v.mrq = mrq; v.mrd = mrd; v.ctl = ctl; v.st = st;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_valid = v.idv; src1 = v.s1; src2 = v.s2; used = v.used;
    ex_valid = v.exv; ex_load = v.ld; dest = v.d; br_taken = v.br;
    mem_req = v.mrq; mem_ready = v.mrd;
  endtask

  task automatic check(input string name, input logic [6:0] ctl, input logic [1:0] st);
    logic [6:0] got;
    got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, ex_mem_valid};
    n_vec++;
    if (got !== ctl || state !== st) begin
      n_bad++;
      $display("FAIL %s: ctl=%b state=%0d, expected ctl=%b state=%0d", name, got, state, ctl, st);
    end
  endtask

  initial begin
    // Stimulus: {idv,s1,s2,used,exv,ld,d,br,mrq,mrd} -> {ctl, state}
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd0)); // idle
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b1100011, 2'd0)); // ldr r3 / add r1,r3,r2
    vecs.push_back(mk(1,3,2,3,0,0,0,0,0,0, 7'b0000000, 2'd1)); // bubble in EX, back to RUN
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd0));
    vecs.push_back(mk(1,1,3,1,1,1,3,0,0,0, 7'b0000001, 2'd0)); // src2 match but unused
    vecs.push_back(mk(1,1,3,2,1,1,3,0,0,0, 7'b1100011, 2'd0)); // src2 match, used
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd1));
    vecs.push_back(mk(1,0,2,1,1,1,0,0,0,0, 7'b1100011, 2'd0)); // r0 is a real register
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd1));
    vecs.push_back(mk(0,3,3,3,1,1,3,0,0,0, 7'b0000001, 2'd0)); // ID invalid
    vecs.push_back(mk(1,1,2,3,1,0,5,1,0,0, 7'b0000111, 2'd0)); // taken branch
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b0000101, 2'd2)); // FLUSH, hazard ignored
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b0000001, 2'd2));
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd0));
    vecs.push_back(mk(1,1,2,3,1,0,5,0,1,0, 7'b1111000, 2'd0)); // mem wait 1
    vecs.push_back(mk(1,1,2,3,1,0,5,0,1,0, 7'b1111000, 2'd3)); // mem wait 2
    vecs.push_back(mk(1,1,2,3,1,0,5,0,1,0, 7'b1111000, 2'd3)); // mem wait 3
    vecs.push_back(mk(1,1,2,3,1,0,5,0,1,1, 7'b0000001, 2'd3)); // ready: stalls drop
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd0));
    vecs.push_back(mk(1,1,2,3,1,0,5,0,1,0, 7'b1111000, 2'd0));
    vecs.push_back(mk(1,3,2,3,1,1,3,1,1,0, 7'b1111000, 2'd3)); // branch+hazard during wait
    vecs.push_back(mk(1,3,2,3,1,1,3,0,1,1, 7'b0000111, 2'd3)); // ready: pending branch flush
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b0000101, 2'd2));
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b0000001, 2'd2));
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd0));
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b1100011, 2'd0)); // hazard
    vecs.push_back(mk(1,3,2,3,1,1,3,1,0,0, 7'b0000111, 2'd1)); // branch aborts LOAD_USE
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000101, 2'd2));
    vecs.push_back(mk(1,1,2,3,1,0,5,0,0,0, 7'b0000001, 2'd2));
    vecs.push_back(mk(1,3,2,3,1,1,3,0,0,0, 7'b1100011, 2'd0)); // hazard
    vecs.push_back(mk(1,3,2,3,1,1,3,0,1,0, 7'b1111000, 2'd1)); // mem wait beats load-use
    vecs.push_back(mk(1,3,2,3,0,0,0,0,1,1, 7'b0000000, 2'd1));
    vecs.push_back(mk(1,1,2,3,1,0,5,0,1,1, 7'b0000001, 2'd0)); // req with ready: no stall

    // Reset held: clean pipeline outputs
    apply(mk(1,1,2,3,1,0,5,0,0,0, 7'b0, 2'd0));
    @(negedge clk); #1;
    check("reset_hold", 7'b0000110, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cycle-by-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec[%0d]", i), vecs[i].ctl, vecs[i].st);
    end

    // Asynchronous reset in the middle of a memory wait
    @(negedge clk);
    apply(mk(1,1,2,3,1,0,5,0,1,0, 7'b0, 2'd0));
    #1;
    check("wait_enter", 7'b1111000, 2'd0);
    @(negedge clk); #1;
    check("wait_hold", 7'b1111000, 2'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_in_wait", 7'b0000110, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(1,1,2,3,1,0,5,0,0,0, 7'b0, 2'd0));
    #1;
    check("after_reset_run", 7'b0000001, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_controller
`default_nettype wire
